mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 137 +++++++++++++
 tb/tb_mem_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter of a fetch port and a data port onto one synchronous memory
module mem_arbiter #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [31:0]       if_rdata,
    output logic              if_ack,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [3:0]        d_be,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic [31:0]       d_rdata,
    output logic              d_ack,
    output logic              mem_en,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic              stall
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        RESP  = 2'd2
    } state_e;

    localparam logic OWNER_IF = 1'b0;
    localparam logic OWNER_D  = 1'b1;

    state_e              state_q, state_d;
    logic                last_owner_q, last_owner_d;
    logic                owner_q, owner_d;
    logic                we_q, we_d;
    logic [3:0]          be_q, be_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;

    logic                any_req;
    logic                win_d;
    logic                grant;

    assign any_req = if_req | d_req;
    // Data wins when it is alone, or on a tie when fetch was served last.
    assign win_d   = d_req & (~if_req | (last_owner_q == OWNER_IF));

    always_comb begin
        state_d      = state_q;
        last_owner_d = last_owner_q;
        owner_d      = owner_q;
        we_d         = we_q;
        be_d         = be_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        grant        = 1'b0;

        case (state_q)
            IDLE: begin
                if (any_req) begin
                    grant   = 1'b1;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                state_d = RESP;
            end
            RESP: begin
                if (any_req) begin
                    grant   = 1'b1;
                    state_d = GRANT;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Request fields are captured only here, so later changes on the ports are ignored.
        if (grant) begin
            owner_d      = win_d ? OWNER_D : OWNER_IF;
            last_owner_d = win_d ? OWNER_D : OWNER_IF;
            if (win_d) begin
                we_d    = d_we;
                be_d    = d_be;
                addr_d  = d_addr;
                wdata_d = d_wdata;
            end else begin
                we_d    = 1'b0;
                be_d    = 4'b1111;
                addr_d  = if_addr;
                wdata_d = 32'h0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            last_owner_q <= OWNER_IF;
            owner_q      <= OWNER_IF;
            we_q         <= 1'b0;
            be_q         <= 4'b0000;
            addr_q       <= '0;
            wdata_q      <= 32'h0;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
            owner_q      <= owner_d;
            we_q         <= we_d;
            be_q         <= be_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
        end
    end

    // Outputs decode straight from the state so an asynchronous reset drops them at once.
    assign mem_en    = (state_q == GRANT);
    assign mem_we    = mem_en & we_q;
    assign mem_be    = be_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    assign if_ack    = (state_q == RESP) & (owner_q == OWNER_IF);
    assign d_ack     = (state_q == RESP) & (owner_q == OWNER_D);
    assign if_rdata  = if_ack ? mem_rdata : 32'h0;
    assign d_rdata   = d_ack  ? mem_rdata : 32'h0;

    assign stall     = (if_req & ~if_ack) | (d_req & ~d_ack);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = 32'h0;
    logic [31:0] if_rdata;
    logic        if_ack;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [3:0]  d_be = 4'h0;
    logic [31:0] d_addr = 32'h0;
    logic [31:0] d_wdata = 32'h0;
    logic [31:0] d_rdata;
    logic        d_ack;
    logic        mem_en;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        stall;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_ack    (if_ack),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_be      (d_be),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_ack     (d_ack),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_be    (mem_be),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .stall     (stall)
    );

    int total = 0;
    int bad = 0;
    bit done = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] init_word(input int i);
        case (i)
            16'h10:  return 32'h00500093;
            16'h40:  return 32'hCAFE0100;
            16'h80:  return 32'h11223344;
            default: return {i[7:0], i[7:0], 8'h5A, 8'hC3};
        endcase
    endfunction

    // Memory environment: synchronous single-port RAM driven by the arbiter.
    logic [31:0] env_mem [0:255];
    logic [31:0] env_rdata = 32'h0;
    bit          env_loaded = 1'b0;
    assign mem_rdata = env_rdata;

    always @(posedge clk) begin
        if (!env_loaded) begin
            for (int i = 0; i < 256; i++) env_mem[i] <= init_word(i);
            env_loaded <= 1'b1;
        end else if (mem_en) begin
            if (mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (mem_be[b]) env_mem[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
            end else begin
                env_rdata <= env_mem[mem_addr[9:2]];
            end
        end
    end

    // Reference model: one transaction in flight, aged 0 while on the memory, 1 while acknowledged.
    logic [31:0] ref_mem [0:255];
    bit          ref_loaded = 1'b0;
    bit          tx_valid = 1'b0;
    bit          tx_age = 1'b0;
    bit          tx_is_d = 1'b0;
    bit          tx_we = 1'b0;
    logic [3:0]  tx_be = 4'h0;
    logic [31:0] tx_addr = 32'h0;
    logic [31:0] tx_wdata = 32'h0;
    logic [31:0] tx_rdata = 32'h0;
    bit          rr_last_d = 1'b0;

    always @(posedge clk or negedge reset) begin
        bit pick_d;
        if (!ref_loaded) begin
            for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
            ref_loaded = 1'b1;
        end
        if (!reset) begin
            tx_valid  = 1'b0;
            tx_age    = 1'b0;
            rr_last_d = 1'b0;
        end else if (tx_valid && !tx_age) begin
            tx_age = 1'b1;
        end else if (if_req || d_req) begin
            if (if_req && d_req) pick_d = !rr_last_d;
            else                 pick_d = d_req;
            rr_last_d = pick_d;
            tx_valid  = 1'b1;
            tx_age    = 1'b0;
            tx_is_d   = pick_d;
            tx_we     = pick_d ? d_we : 1'b0;
            tx_be     = pick_d ? d_be : 4'b1111;
            tx_addr   = pick_d ? d_addr : if_addr;
            tx_wdata  = pick_d ? d_wdata : 32'h0;
            if (tx_we) begin
                for (int b = 0; b < 4; b++)
                    if (tx_be[b]) ref_mem[tx_addr[9:2]][8*b +: 8] = tx_wdata[8*b +: 8];
            end else begin
                tx_rdata = ref_mem[tx_addr[9:2]];
            end
        end else begin
            tx_valid = 1'b0;
        end
    end

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        bit e_en, e_iack, e_dack;
        if (!done) begin
            e_en   = tx_valid && !tx_age;
            e_iack = tx_valid && tx_age && !tx_is_d;
            e_dack = tx_valid && tx_age && tx_is_d;
            check("mem_en", {31'h0, mem_en}, {31'h0, e_en});
            check("mem_we", {31'h0, mem_we}, {31'h0, e_en && tx_we});
            if (e_en) begin
                check("mem_be", {28'h0, mem_be}, {28'h0, tx_be});
                check("mem_addr", mem_addr, tx_addr);
                check("mem_wdata", mem_wdata, tx_wdata);
            end
            check("if_ack", {31'h0, if_ack}, {31'h0, e_iack});
            check("d_ack", {31'h0, d_ack}, {31'h0, e_dack});
            check("if_rdata", if_rdata, e_iack ? tx_rdata : 32'h0);
            if (!e_dack)     check("d_rdata_idle", d_rdata, 32'h0);
            else if (!tx_we) check("d_rdata", d_rdata, tx_rdata);
            check("stall", {31'h0, stall},
                  {31'h0, (if_req && !e_iack) || (d_req && !e_dack)});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3 reset = 1'b0;
        @(posedge clk);
        #3 reset = 1'b1;
    endtask

    initial begin
        int d_cyc, i_cyc, overlap, d_cnt, i_cnt;
        bit first_d;

        @(posedge clk);
        #2;
        check("rst_mem_en", {31'h0, mem_en}, 32'h0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_be", {28'h0, mem_be}, 32'h0);
        check("rst_acks", {30'h0, if_ack, d_ack}, 32'h0);
        @(posedge clk);
        #3 reset = 1'b1;

        // Single fetch
        if_addr = 32'h40;
        if_req  = 1'b1;
        tick();
        check("t1_mem_en", {31'h0, mem_en}, 32'h1);
        check("t1_mem_addr", mem_addr, 32'h40);
        check("t1_stall", {31'h0, stall}, 32'h1);
        tick();
        check("t1_if_ack", {31'h0, if_ack}, 32'h1);
        check("t1_if_rdata", if_rdata, 32'h00500093);
        if_req = 1'b0;
        tick();
        check("t1_idle", {30'h0, mem_en, if_ack}, 32'h0);

        // Tie from reset: data first
        if_req = 1'b1; if_addr = 32'h40;
        d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h100;
        do_reset();
        d_cyc = 0; i_cyc = 0; overlap = 0;
        for (int c = 1; c <= 6; c++) begin
            tick();
            if (d_ack && if_ack) overlap++;
            if (d_ack) begin d_cyc = c; d_req = 1'b0; end
            if (if_ack) begin i_cyc = c; if_req = 1'b0; end
        end
        check("t2_d_ack_cycle", d_cyc, 2);
        check("t2_if_ack_cycle", i_cyc, 4);
        check("t2_overlap", overlap, 0);

        // Sustained contention
        if_req = 1'b1; d_req = 1'b1;
        do_reset();
        d_cnt = 0; i_cnt = 0; first_d = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (d_ack) d_cnt++;
            if (if_ack) i_cnt++;
            if (c == 2) first_d = d_ack;
        end
        if_req = 1'b0; d_req = 1'b0;
        check("t3_d_acks", d_cnt, 5);
        check("t3_if_acks", i_cnt, 5);
        check("t3_first_is_d", {31'h0, first_d}, 32'h1);
        tick();
        tick();

        // Byte store followed by a fetch of the same word
        d_we = 1'b1; d_be = 4'b0100; d_addr = 32'h202; d_wdata = 32'h00AB0000; d_req = 1'b1;
        tick();
        check("t4_mem_we", {31'h0, mem_we}, 32'h1);
        check("t4_mem_be", {28'h0, mem_be}, 32'h4);
        check("t4_mem_addr", mem_addr, 32'h202);
        check("t4_mem_wdata", mem_wdata, 32'h00AB0000);
        tick();
        check("t4_d_ack", {31'h0, d_ack}, 32'h1);
        check("t4_if_ack", {31'h0, if_ack}, 32'h0);
        d_req = 1'b0; d_we = 1'b0; d_be = 4'hF;
        tick();
        if_addr = 32'h200; if_req = 1'b1;
        tick();
        tick();
        check("t4_readback", if_rdata, 32'h11AB3344);
        if_req = 1'b0;
        tick();

        // Reset during GRANT aborts the access
        d_addr = 32'h100; d_req = 1'b1;
        tick();
        #2 reset = 1'b0;
        d_req = 1'b0;
        #1;
        check("t5_mem_en_drop", {31'h0, mem_en}, 32'h0);
        check("t5_d_ack_abort", {31'h0, d_ack}, 32'h0);
        @(posedge clk);
        #3 reset = 1'b1;
        d_cnt = 0;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (d_ack) d_cnt++;
        end
        check("t5_no_d_ack", d_cnt, 0);
        if_addr = 32'h40; if_req = 1'b1;
        tick();
        check("t5_fetch_addr", mem_addr, 32'h40);
        tick();
        check("t5_fetch_ack", {31'h0, if_ack}, 32'h1);
        check("t5_fetch_data", if_rdata, 32'h00500093);
        if_req = 1'b0;
        tick();

        // Request dropped during GRANT still completes; field changes are ignored
        d_addr = 32'h100; d_we = 1'b0; d_req = 1'b1;
        tick();
        d_req = 1'b0;
        d_addr = 32'h204;
        #1;
        check("t6_addr_held", mem_addr, 32'h100);
        d_cnt = 0;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (d_ack) begin
                d_cnt++;
                check("t6_d_rdata", d_rdata, 32'hCAFE0100);
            end
        end
        check("t6_one_ack", d_cnt, 1);
        check("t6_idle", {31'h0, mem_en}, 32'h0);

        done = 1'b1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
